// File: rtl/pipe_pkg.sv
// ============================================================================
// pipe_pkg : shared types and constants for the elastic pipeline stages
// Revision : 1.0
// ============================================================================
`default_nettype none

package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

endpackage

`default_nettype wire

// File: rtl/pipe_stage_ctrl.sv
// ============================================================================
// pipe_stage_ctrl : occupancy FSM, in_ready and datapath load-enables
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_ctrl
    import pipe_pkg::*;
#(
    parameter bit SKID_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    input  logic       out_ready,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] occupancy,
    output logic       main_ld_in,
    output logic       main_ld_skid,
    output logic       main_clr,
    output logic       skid_ld
);

    pipe_state_t state_q;
    pipe_state_t state_d;
    logic        in_fire;
    logic        out_fire;

    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d      = state_q;
        main_ld_in   = 1'b0;
        main_ld_skid = 1'b0;
        main_clr     = 1'b0;
        skid_ld      = 1'b0;
        if (flush) begin
            // an accepted input in this cycle is deliberately dropped
            state_d  = EMPTY;
            main_clr = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d    = ONE;
                        main_ld_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_ld_in = 1'b1;
                    end else if (in_fire) begin
                        if (SKID_EN) begin
                            state_d = TWO;
                            skid_ld = 1'b1;
                        end
                    end else if (out_fire) begin
                        state_d  = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_d      = ONE;
                        main_ld_skid = 1'b1;
                    end
                end
                default: begin
                    state_d  = EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    generate
        if (SKID_EN) begin : g_skid
            logic in_ready_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    in_ready_q <= 1'b1;
                end else begin
                    in_ready_q <= (state_d != TWO);
                end
            end
            assign in_ready = in_ready_q;
        end else begin : g_single
            assign in_ready = (state_q == EMPTY) | out_ready;
        end
    endgenerate

    always_comb begin
        case (state_q)
            ONE:     occupancy = 2'd1;
            TWO:     occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pipe_stage_elastic.sv
// ============================================================================
// pipe_stage_elastic : valid/ready pipeline register with skid entry and flush
// Revision : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                 DATA_W  = 64,
    parameter logic [DATA_W-1:0]  BUBBLE  = DATA_W'(NOP_INSTR),
    parameter bit                 SKID_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_ld_in;
    logic              main_ld_skid;
    logic              main_clr;
    logic              skid_ld;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;

    pipe_stage_ctrl #(
        .SKID_EN (SKID_EN)
    ) u_ctrl (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .out_ready    (out_ready),
        .in_ready     (in_ready),
        .out_valid    (out_valid),
        .occupancy    (occupancy),
        .main_ld_in   (main_ld_in),
        .main_ld_skid (main_ld_skid),
        .main_clr     (main_clr),
        .skid_ld      (skid_ld)
    );

    // main is forced to BUBBLE whenever it empties, so out_data needs no mux
    always_comb begin
        main_d = main_q;
        if (main_clr) begin
            main_d = BUBBLE;
        end else if (main_ld_in) begin
            main_d = in_data;
        end else if (main_ld_skid) begin
            main_d = skid_q;
        end
        skid_d = skid_ld ? in_data : skid_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q <= BUBBLE;
        end else begin
            main_q <= main_d;
        end
    end

    always_ff @(posedge clk) begin
        skid_q <= skid_d;
    end

    assign out_data = main_q;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_elastic.sv
// ============================================================================
// tb_pipe_stage_elastic : queue-model scoreboard for the skid stage plus
// directed checks of the single-entry variant
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_pipe_stage_elastic;

    localparam logic [63:0] BUB = 64'h0000_0000_0000_0020;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v1, r1o, fl1;
    logic [63:0] d1;
    logic        ir1, ov1;
    logic [63:0] od1;
    logic [1:0]  oc1;

    logic        v0, r0o, fl0;
    logic [63:0] d0;
    logic        ir0, ov0;
    logic [63:0] od0;
    logic [1:0]  oc0;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic        rdy_exp = 1'b1;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_elastic #(.DATA_W(64), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(fl1),
        .in_valid(v1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(r1o), .out_data(od1), .occupancy(oc1)
    );

    pipe_stage_elastic #(.DATA_W(64), .SKID_EN(1'b0)) dut_single (
        .clk(clk), .rst_n(rst_n), .flush(fl0),
        .in_valid(v0), .in_ready(ir0), .in_data(d0),
        .out_valid(ov0), .out_ready(r0o), .out_data(od0), .occupancy(oc0)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Reference: a 2-deep FIFO of held entries; acceptance needs room for one more.
    always @(posedge clk) begin
        if (!rst_n || fl1) begin
            exp_q.delete();
        end else if (v1 && rdy_exp) begin
            exp_q.push_back(d1);
        end
    end

    always @(negedge clk) begin
        int n;
        if (mon_en) begin
            n = exp_q.size();
            rdy_exp = (n < 2);
            check("in_ready", 64'(ir1), 64'(rdy_exp));
            check("out_valid", 64'(ov1), 64'(n > 0));
            check("occupancy", 64'(oc1), 64'(n));
            check("out_data", od1, (n > 0) ? exp_q[0] : BUB);
            if (n > 0 && r1o) begin
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [63:0] d, input logic ordy, input logic fl);
        v1  = v;
        d1  = d;
        r1o = ordy;
        fl1 = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        v1 = 1'b0; d1 = '0; r1o = 1'b0; fl1 = 1'b0;
        v0 = 1'b0; d0 = '0; r0o = 1'b0; fl0 = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // single-entry variant: reset values, stall, simultaneous pass
        check("s0_rst_valid", 64'(ov0), 64'd0);
        check("s0_rst_data", od0, BUB);
        check("s0_rst_occ", 64'(oc0), 64'd0);
        check("s0_rst_ready", 64'(ir0), 64'd1);
        v0 = 1'b1; d0 = 64'hC1; r0o = 1'b0;
        @(posedge clk); #1;
        v0 = 1'b0;
        check("s0_c1_valid", 64'(ov0), 64'd1);
        check("s0_c1_data", od0, 64'hC1);
        check("s0_stall_ready", 64'(ir0), 64'd0);
        @(posedge clk); #1;
        check("s0_c1_stable", od0, 64'hC1);
        check("s0_c1_valid_hold", 64'(ov0), 64'd1);
        r0o = 1'b1; v0 = 1'b1; d0 = 64'hC2;
        #1;
        check("s0_pass_ready", 64'(ir0), 64'd1);
        @(posedge clk); #1;
        v0 = 1'b0;
        check("s0_c2_data", od0, 64'hC2);
        check("s0_c2_occ", 64'(oc0), 64'd1);
        @(posedge clk); #1;
        check("s0_drain_valid", 64'(ov0), 64'd0);
        check("s0_drain_data", od0, BUB);

        // streaming
        cyc(1'b1, 64'h11, 1'b1, 1'b0);
        cyc(1'b1, 64'h22, 1'b1, 1'b0);
        cyc(1'b1, 64'h33, 1'b1, 1'b0);
        repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        // skid fill, upstream held, release
        cyc(1'b1, 64'hA1, 1'b0, 1'b0);
        cyc(1'b1, 64'hA2, 1'b0, 1'b0);
        repeat (3) cyc(1'b1, 64'hA3, 1'b0, 1'b0);
        repeat (2) cyc(1'b1, 64'hA3, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        // flush while two entries held, with an offered entry
        cyc(1'b1, 64'hB1, 1'b0, 1'b0);
        cyc(1'b1, 64'hB2, 1'b0, 1'b0);
        cyc(1'b1, 64'hB3, 1'b0, 1'b1);
        repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        // reset while two entries held
        cyc(1'b1, 64'hD1, 1'b0, 1'b0);
        cyc(1'b1, 64'hD2, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc(1'b0, 64'h0, 1'b0, 1'b0);
        rst_n = 1'b1;
        repeat (2) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        // randomized traffic with occasional flush and reset
        repeat (3000) begin
            rst_n = ($urandom_range(0, 99) != 0);
            cyc(1'($urandom_range(0, 1)), {$urandom, $urandom},
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        rst_n = 1'b1;
        repeat (3) cyc(1'b0, 64'h0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised, elastic pipeline-stage register for the pipelined processor, replacing the fixed-width, fixed-stall stage registers between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload under a valid/ready handshake and holds up to two entries (main + skid) so `in_ready` can be registered. It supports flush with bubble (NOP) insertion and exposes occupancy to the hazard unit.

## Interface
Parameters:
- `DATA_W`, 64, payload width (e.g. Instr + PC+1 concatenated).
- `BUBBLE`, `{DATA_W{1'b0}} | 32'h0000_0020`, value driven on `out_data` whenever the stage is empty (NOP in low 32 bits).
- `SKID_EN`, 1, 1 = two-entry skid mode with registered `in_ready`; 0 = single-entry mode with combinational `in_ready`.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset; one clock, reset synchronous and active-low.
- `flush`  in  1  discard all held and incoming entries this cycle.
- `in_valid`  in  1  upstream has an entry.
- `in_ready`  out  1  stage accepts an entry this cycle.
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` is a real entry.
- `out_ready`  in  1  downstream accepts (hazard unit drives `~stall`).
- `out_data`  out  DATA_W  payload; equals `BUBBLE` when `out_valid`=0.
- `occupancy`  out  2  entries held: 0, 1 or 2.

## Operation
- `in_fire = in_valid & in_ready`; `out_fire = out_valid & out_ready`.
- States: EMPTY (occupancy 0), ONE (main full), TWO (main + skid full; only if `SKID_EN`=1).
- EMPTY: `in_fire` → ONE, main ← `in_data`; else hold.
- ONE: `in_fire & out_fire` → ONE, main ← `in_data`; `in_fire & ~out_fire` → TWO, skid ← `in_data` (`SKID_EN`=0: cannot occur); `~in_fire & out_fire` → EMPTY, main ← `BUBBLE`; else hold.
- TWO: `in_ready`=0, no `in_fire`; `out_fire` → ONE, main ← skid; else hold.
- `in_ready`: `SKID_EN`=1 → registered, 1 iff next state ≠ TWO. `SKID_EN`=0 → combinational, `(state==EMPTY) | out_ready`.
- Priority: `rst_n`=0 > `flush` > handshake.
- `flush`=1: next state EMPTY, main ← `BUBBLE`, skid discarded. An `in_fire` in the same cycle is consumed from upstream and dropped. `out_fire` in that cycle still completes downstream.
- Data ordering strictly FIFO; no entry duplicated or lost except by flush.
- `out_data` is driven directly from the main register; no combinational path from `in_data` to `out_data`.

## Timing
- Reset (`rst_n`=0 at edge): state EMPTY, `out_valid`=0, `out_data`=`BUBBLE`, `occupancy`=0, `in_ready`=1, skid contents don't-care.
- Latency: 1 cycle, `in_fire` at edge N → `out_valid`=1 with that data after edge N.
- Throughput: 1 entry/cycle with `out_ready` held high.
- `SKID_EN`=1: `in_ready` falls one cycle after the first stalled acceptance. Exactly one extra entry is absorbed.
- Flush applies at the edge it is sampled. The next cycle shows `out_valid`=0, `out_data`=`BUBBLE`, `in_ready`=1.
- Reset or flush while in TWO: both entries lost, no partial output.
- `out_valid` and `out_data` are stable while `out_valid & ~out_ready`.

## Structure
- Shared package `pipe_pkg`:
  - `pipe_state_t` enum (EMPTY=2'd0, ONE=2'd1, TWO=2'd2).
  - `NOP_INSTR` = 32'h0000_0020, used as the `BUBBLE` default.
- One sub-module, `pipe_stage_ctrl`:
  - FSM plus `in_ready` and `occupancy` generation.
  - Outputs load-enables (`main_ld_in`, `main_ld_skid`, `main_clr`, `skid_ld`).
  - The top level holds the main/skid datapath registers.

## Test plan
- Reset: `rst_n`=0 for 2 cycles → `out_valid`=0, `out_data`=…0020, `occupancy`=0, `in_ready`=1.
- Streaming: `out_ready`=1, feed 0x11,0x22,0x33 back-to-back → outputs 0x11,0x22,0x33 on the 3 consecutive cycles after each input; `occupancy` stays 1.
- Skid (`SKID_EN`=1): `out_ready`=0, feed 0xA1,0xA2,0xA3:
  - 0xA1 and 0xA2 are accepted; `in_ready`=0 thereafter; `occupancy`=2.
  - 0xA3 is held upstream.
  - Release `out_ready` → outputs 0xA1,0xA2,0xA3 in order.
- Flush in TWO: state TWO with 0xB1/0xB2, assert `flush` with `in_valid`=1, `in_data`=0xB3 → next cycle `out_valid`=0, `out_data`=BUBBLE, `occupancy`=0; 0xB3 never appears.
- `SKID_EN`=0 stall: `out_ready`=0 with 0xC1 held → `in_ready`=0 same cycle, 0xC1 stable; `out_ready`=1 with `in_valid` on 0xC2 → simultaneous pass, output 0xC2 next cycle.
- Reset mid-stream: `rst_n`=0 while `occupancy`=2 → next cycle all outputs at reset values.
